// File: rtl/cnn_core_mac_arbiter.sv
// Round-robin sharing of one signed 16x6 multiplier among NUM_REQ dot-product
// streams. Each stream has its own accumulator; finished sums leave on one result port.
module cnn_core_mac_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ACC_W   = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_data,
  input  logic [6*NUM_REQ-1:0]  req_wght,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_W-1:0]      res_data,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy
);

  logic [ID_W-1:0]         r_rr_ptr;
  logic                    r_p_vld;
  logic                    r_p_last;
  logic signed [21:0]      r_p_prod;
  logic [ID_W-1:0]         r_p_id;
  logic signed [ACC_W-1:0] r_acc [NUM_REQ];
  logic [NUM_REQ-1:0]      r_job_open;
  logic                    r_res_valid;
  logic [ACC_W-1:0]        r_res_data;
  logic [ID_W-1:0]         r_res_id;

  logic                    w_last_blocked;
  logic [NUM_REQ-1:0]      w_eligible;
  logic                    w_grant;
  logic [ID_W-1:0]         w_grant_id;
  logic signed [15:0]      w_data;
  logic signed [5:0]       w_wght;
  logic                    w_last;
  logic signed [21:0]      w_prod;
  logic signed [ACC_W-1:0] w_sum;

  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    return (v >= NUM_REQ) ? ID_W'(v - NUM_REQ) : ID_W'(v);
  endfunction

  // A last beat may only enter when the result path is guaranteed free on arrival.
  assign w_last_blocked = r_res_valid | (r_p_vld & r_p_last);
  assign w_eligible     = req_valid & (~req_last | {NUM_REQ{~w_last_blocked}});

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_grant    = 1'b0;
    w_grant_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant && w_eligible[wrap_idx(int'(r_rr_ptr) + k)]) begin
        w_grant    = 1'b1;
        w_grant_id = wrap_idx(int'(r_rr_ptr) + k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant && !ap_rst) req_ready[w_grant_id] = 1'b1;
  end

  assign w_data = req_data[int'(w_grant_id)*16 +: 16];
  assign w_wght = req_wght[int'(w_grant_id)*6 +: 6];
  assign w_last = req_last[w_grant_id];
  assign w_prod = 22'(w_data) * 22'(w_wght);
  assign w_sum  = r_acc[r_p_id] + ACC_W'(r_p_prod);

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_rr_ptr   <= '0;
      r_p_vld    <= 1'b0;
      r_p_last   <= 1'b0;
      r_p_prod   <= '0;
      r_p_id     <= '0;
      r_job_open <= '0;
    end else begin
      r_p_vld  <= w_grant;
      r_p_last <= w_grant & w_last;
      r_p_prod <= w_prod;
      r_p_id   <= w_grant_id;
      if (w_grant) begin
        r_rr_ptr               <= (int'(w_grant_id) == NUM_REQ-1) ? '0 : w_grant_id + ID_W'(1);
        r_job_open[w_grant_id] <= ~w_last;
      end
    end
  end

  // NOTE: the accumulator array is reset on purpose; a reset must discard every partial sum.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_acc[i] <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      if (r_res_valid && res_ready) r_res_valid <= 1'b0;
      if (r_p_vld) begin
        if (r_p_last) begin
          r_acc[r_p_id] <= '0;
          r_res_valid   <= 1'b1;
          r_res_data    <= w_sum;
          r_res_id      <= r_p_id;
        end else begin
          r_acc[r_p_id] <= w_sum;
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = r_p_vld | r_res_valid | (|r_job_open);

endmodule

// File: tb/tb_cnn_core_mac_arbiter.sv
// Bench for cnn_core_mac_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of grants, sums and results.
module tb_cnn_core_mac_arbiter;

  localparam int N = 4;

  logic            ap_clk    = 1'b0;
  logic            ap_rst    = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [16*N-1:0] req_data  = '0;
  logic [6*N-1:0]  req_wght  = '0;
  logic            res_ready = 1'b0;

  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic [31:0]     res_data;
  logic [1:0]      res_id;
  logic            busy;

  logic [N-1:0]    x_req_ready;
  logic            x_res_valid;
  logic [21:0]     x_res_data;
  logic [1:0]      x_res_id;
  logic            x_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int         cyc;
  int         m_rr;
  bit [N-1:0] m_open;
  longint     m_acc [N];
  bit         m_out;
  int         m_out_cyc;
  longint     m_out_data;
  int         m_out_id;
  bit         m_pvld_prev;

  cnn_core_mac_arbiter #(.NUM_REQ(N), .ID_W(2), .ACC_W(32)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_wght(req_wght), .req_last(req_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  cnn_core_mac_arbiter #(.NUM_REQ(N), .ID_W(2), .ACC_W(22)) dut22 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(x_req_ready), .req_data(req_data),
    .req_wght(req_wght), .req_last(req_last),
    .res_valid(x_res_valid), .res_ready(res_ready), .res_data(x_res_data),
    .res_id(x_res_id), .busy(x_busy)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [16*N-1:0] put_d(input int idx, input int val);
    logic [16*N-1:0] r;
    r = '0;
    r[16*idx +: 16] = 16'(val);
    return r;
  endfunction

  function automatic logic [6*N-1:0] put_w(input int idx, input int val);
    logic [6*N-1:0] r;
    r = '0;
    r[6*idx +: 6] = 6'(val);
    return r;
  endfunction

  task automatic model_reset();
    cyc         = 0;
    m_rr        = 0;
    m_open      = '0;
    m_out       = 1'b0;
    m_out_cyc   = 0;
    m_out_data  = 0;
    m_out_id    = 0;
    m_pvld_prev = 1'b0;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst    = 1'b1;
    req_valid = '0;
    req_last  = '0;
    res_ready = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [16*N-1:0] d, input logic [6*N-1:0] w, input logic rr);
    int         g;
    int         i;
    logic [N-1:0] exp_ready;
    bit         exp_rv;
    bit         exp_busy;
    @(negedge ap_clk);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    req_wght  = w;
    res_ready = rr;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (g < 0 && v[i] && (!l[i] || !m_out)) g = i;
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    exp_rv    = m_out && (cyc >= m_out_cyc);
    exp_busy  = m_pvld_prev || m_out || (|m_open);

    n_checks++;
    if (req_ready !== exp_ready) begin
      n_errors++;
      $display("FAIL req_ready cyc %0d: got %b expected %b", cyc, req_ready, exp_ready);
    end
    n_checks++;
    if (res_valid !== exp_rv) begin
      n_errors++;
      $display("FAIL res_valid cyc %0d: got %b expected %b", cyc, res_valid, exp_rv);
    end
    if (exp_rv) begin
      n_checks++;
      if (res_data !== 32'(m_out_data) || res_id !== 2'(m_out_id)) begin
        n_errors++;
        $display("FAIL res_data cyc %0d: got %0d id %0d expected %0d id %0d",
                 cyc, $signed(res_data), res_id, int'(32'(m_out_data)), m_out_id);
      end
    end
    n_checks++;
    if (busy !== exp_busy) begin
      n_errors++;
      $display("FAIL busy cyc %0d: got %b expected %b", cyc, busy, exp_busy);
    end

    if (exp_rv && rr) m_out = 1'b0;
    if (g >= 0) begin
      m_acc[g] += longint'($signed(d[16*g +: 16])) * longint'($signed(w[6*g +: 6]));
      m_open[g] = !l[g];
      if (l[g]) begin
        m_out      = 1'b1;
        m_out_cyc  = cyc + 2;
        m_out_data = m_acc[g];
        m_out_id   = g;
        m_acc[g]   = 0;
      end
      m_rr = (g + 1) % N;
    end
    m_pvld_prev = (g >= 0);
    cyc++;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (req_ready !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%0h id=%0d busy=%b expected all zero",
               req_ready, res_valid, res_data, res_id, busy);
    end
    n_checks++;
    if (x_res_valid !== 1'b0 || x_res_data !== '0 || x_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs_acc22: valid=%b data=%0h busy=%b expected all zero",
               x_res_valid, x_res_data, x_busy);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_job();
    do_reset();
    step(4'b0001, 4'b0000, put_d(0, 100),  put_w(0, 3),   1'b1);
    step(4'b0001, 4'b0000, put_d(0, -200), put_w(0, 5),   1'b1);
    step(4'b0001, 4'b0001, put_d(0, 7),    put_w(0, -32), 1'b1);
    step(4'b0000, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_latency_t1: res_valid=%b expected 0", res_valid);
    end
    step(4'b0000, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'(-924) || res_id !== 2'd0) begin
      n_errors++;
      $display("FAIL single_result: valid=%b data=%0d id=%0d expected 1 -924 0",
               res_valid, $signed(res_data), res_id);
    end
  endtask

  task automatic test_round_robin();
    int cnt [N];
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      step(4'b1111, 4'b0000, {$urandom, $urandom}, 24'($urandom), 1'b1);
      n_checks++;
      if (req_ready !== N'(1 << (k % N))) begin
        n_errors++;
        $display("FAIL rr_order cyc %0d: got %b expected %b", k, req_ready, N'(1 << (k % N)));
      end
      for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) cnt[i]++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cnt[i] != 4) begin
        n_errors++;
        $display("FAIL rr_share req %0d: got %0d grants expected 4", i, cnt[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(4'b0001, 4'b0001, put_d(0, 3), put_w(0, 4), 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(4'b0110, 4'b0010, put_d(1, -9) | put_d(2, k + 1), put_w(1, 11) | put_w(2, 2), 1'b0);
      n_checks++;
      if (req_ready !== 4'b0100) begin
        n_errors++;
        $display("FAIL stall_grant cyc %0d: got %b expected 0100", k, req_ready);
      end
    end
    step(4'b0110, 4'b0010, put_d(1, -9) | put_d(2, 7), put_w(1, 11) | put_w(2, 2), 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd12 || res_id !== 2'd0 || req_ready !== 4'b0100) begin
      n_errors++;
      $display("FAIL stall_release: valid=%b data=%0d id=%0d ready=%b expected 1 12 0 0100",
               res_valid, $signed(res_data), res_id, req_ready);
    end
    step(4'b0110, 4'b0010, put_d(1, -9) | put_d(2, 8), put_w(1, 11) | put_w(2, 2), 1'b1);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_errors++;
      $display("FAIL stall_last_grant: got %b expected 0010", req_ready);
    end
    step(4'b0100, 4'b0000, put_d(2, 9), put_w(2, 2), 1'b1);
    step(4'b0000, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'(-99) || res_id !== 2'd1) begin
      n_errors++;
      $display("FAIL stall_second_result: valid=%b data=%0d id=%0d expected 1 -99 1",
               res_valid, $signed(res_data), res_id);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int b = 0; b < 1000; b++)
      step(4'b0001, (b == 999) ? 4'b0001 : 4'b0000, put_d(0, -32768), put_w(0, -32), 1'b1);
    step(4'b0000, 4'b0000, '0, '0, 1'b1);
    step(4'b0000, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd1048576000) begin
      n_errors++;
      $display("FAIL extreme_acc32: valid=%b data=%0d expected 1 1048576000", res_valid, res_data);
    end
    n_checks++;
    if (x_res_valid !== 1'b1 || x_res_data !== 22'd0 || x_res_id !== 2'd0) begin
      n_errors++;
      $display("FAIL extreme_acc22_wrap: valid=%b data=%0h id=%0d expected 1 0 0",
               x_res_valid, x_res_data, x_res_id);
    end
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    step(4'b0001, 4'b0001, put_d(0, 2), put_w(0, 2), 1'b0);
    step(4'b1000, 4'b0000, put_d(3, 10), put_w(3, 10), 1'b0);
    step(4'b1000, 4'b0000, put_d(3, 20), put_w(3, -3), 1'b0);
    step(4'b0000, 4'b0000, '0, '0, 1'b0);
    @(negedge ap_clk);
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    req_data  = put_d(3, 30);
    req_wght  = put_w(3, 1);
    #2;
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midjob_reset: ready=%b valid=%b data=%0h id=%0d busy=%b expected all zero",
               req_ready, res_valid, res_data, res_id, busy);
    end
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    req_valid = '0;
    model_reset();
    step(4'b1000, 4'b1000, put_d(3, 5), put_w(3, 5), 1'b1);
    step(4'b0000, 4'b0000, '0, '0, 1'b1);
    step(4'b0000, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd25 || res_id !== 2'd3) begin
      n_errors++;
      $display("FAIL fresh_job_after_reset: valid=%b data=%0d id=%0d expected 1 25 3",
               res_valid, $signed(res_data), res_id);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [N-1:0] l;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      v = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 9) < 3);
      step(v, l, {$urandom, $urandom}, 24'($urandom), ($urandom_range(0, 9) < 6));
    end
    for (int k = 0; k < 16; k++) step(4'b1111, 4'b1111, {$urandom, $urandom}, 24'($urandom), 1'b1);
    for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, '0, '0, 1'b1);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_idle: busy=%b res_valid=%b expected 0 0", busy, res_valid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_job();
    test_round_robin();
    test_stall();
    test_extremes();
    test_reset_mid_job();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
